// File: rtl/conv_kernel_param.sv
// Shared encodings for the conv layer controller handshake and input-stage FSM.
package conv_kernel_param;

  localparam int unsigned CMD_WIDTH = 2;
  localparam int unsigned ACK_WIDTH = 2;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_IDLE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_SHIFT = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef enum logic [ACK_WIDTH-1:0] {
    ACK_IDLE      = 2'd0,
    ACK_LOAD_FIN  = 2'd1,
    ACK_SHIFT_FIN = 2'd2
  } ack_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_RD   = 3'd1,
    ST_LOAD_WAIT = 3'd2,
    ST_LOAD_ACK  = 3'd3,
    ST_SHIFT     = 3'd4
  } in_state_e;

  // Pixels per image row (and rows per image) for a valid-convolution array.
  function automatic int unsigned image_size(input int unsigned array_size,
                                             input int unsigned kernel_size);
    return array_size + kernel_size - 1;
  endfunction

endpackage

// File: rtl/conv_input_interface_if.sv
// Command/ack handshake, image-memory read port and window output of the conv input stage.
interface conv_input_interface_if #(
  parameter int unsigned KERNEL_SIZE = 2,
  parameter int unsigned ARRAY_WIDTH = 3,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 6
) ();

  localparam int unsigned WIN_WIDTH = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  logic [1:0]             cmd;
  logic [1:0]             ack;
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_rd_addr;
  logic [DATA_WIDTH-1:0]  mem_rd_data;
  logic [WIN_WIDTH-1:0]   window_data;
  logic                   window_valid;
  logic [ARRAY_WIDTH-1:0] col_idx;

  // Controller plus image memory side.
  modport master (
    output cmd,
    output mem_rd_data,
    input  ack,
    input  mem_rd_en,
    input  mem_rd_addr,
    input  window_data,
    input  window_valid,
    input  col_idx
  );

  // Input stage side.
  modport slave (
    input  cmd,
    input  mem_rd_data,
    output ack,
    output mem_rd_en,
    output mem_rd_addr,
    output window_data,
    output window_valid,
    output col_idx
  );

endinterface

// File: rtl/conv_line_buffer.sv
// KERNEL_SIZE x IMAGE_SIZE pixel line buffer; row 0 is the oldest row.
// Rotate discards the oldest row and clears the newest slot for the incoming load.
module conv_line_buffer #(
  parameter int unsigned KERNEL_SIZE = 2,
  parameter int unsigned IMAGE_SIZE  = 7,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COL_WIDTH   = 3,
  parameter int unsigned IDX_WIDTH   = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       rotate,
  input  logic                                       wr_en,
  input  logic [IDX_WIDTH-1:0]                       wr_idx,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  input  logic [COL_WIDTH-1:0]                       rd_col,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] rd_window
);

  logic [DATA_WIDTH-1:0] rows_q [KERNEL_SIZE][IMAGE_SIZE];

  // Rotation and writes never overlap: writes only follow the rotate by at least two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
        for (int c = 0; c < int'(IMAGE_SIZE); c++) begin
          rows_q[r][c] <= '0;
        end
      end
    end else if (rotate) begin
      for (int r = 0; r < int'(KERNEL_SIZE) - 1; r++) begin
        for (int c = 0; c < int'(IMAGE_SIZE); c++) begin
          rows_q[r][c] <= rows_q[r+1][c];
        end
      end
      for (int c = 0; c < int'(IMAGE_SIZE); c++) begin
        rows_q[KERNEL_SIZE-1][c] <= '0;
      end
    end else if (wr_en) begin
      rows_q[KERNEL_SIZE-1][wr_idx] <= wr_data;
    end
  end

  // Window element (r,c) comes from column rd_col+c of buffered row r.
  always_comb begin
    rd_window = '0;
    for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
      for (int c = 0; c < int'(KERNEL_SIZE); c++) begin
        rd_window[(r*int'(KERNEL_SIZE)+c)*int'(DATA_WIDTH) +: DATA_WIDTH] =
          rows_q[r][IDX_WIDTH'(int'(rd_col) + c)];
      end
    end
  end

endmodule

// File: rtl/conv_input_interface.sv
// Conv layer input stage: loads image rows into the line buffer and emits one window per shift.
// Optional CONV_INPUT_CMD_ERR_EN adds a sticky cmd_err flag for out-of-protocol commands.
module conv_input_interface
  import conv_kernel_param::*;
#(
  parameter int unsigned KERNEL_SIZE = 2,
  parameter int unsigned ARRAY_SIZE  = 6,
  parameter int unsigned ARRAY_WIDTH = 3,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_input_interface_if.slave  bus
`ifdef CONV_INPUT_CMD_ERR_EN
  ,
  output logic                   cmd_err
`endif
);

  localparam int unsigned IMAGE_SIZE = image_size(ARRAY_SIZE, KERNEL_SIZE);
  localparam int unsigned IDX_WIDTH  = $clog2(IMAGE_SIZE);
  localparam int unsigned WIN_WIDTH  = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  in_state_e              state_q, state_n;
  logic [IDX_WIDTH-1:0]   rd_idx_q, rd_idx_n;
  logic [IDX_WIDTH-1:0]   row_ptr_q, row_ptr_n;
  logic [ARRAY_WIDTH-1:0] col_ptr_q, col_ptr_n;
  logic [ARRAY_WIDTH-1:0] col_idx_q, col_idx_n;
  ack_e                   ack_q, ack_n;
  logic                   mem_rd_en_q, mem_rd_en_n;
  logic [ADDR_WIDTH-1:0]  mem_rd_addr_q, mem_rd_addr_n;
  logic [WIN_WIDTH-1:0]   window_q, window_n;
  logic                   window_valid_q, window_valid_n;
  logic                   wr_vld_q;
  logic [IDX_WIDTH-1:0]   wr_idx_q;
  logic                   rotate_c;
  logic [WIN_WIDTH-1:0]   win_c;

  conv_line_buffer #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMAGE_SIZE  (IMAGE_SIZE),
    .DATA_WIDTH  (DATA_WIDTH),
    .COL_WIDTH   (ARRAY_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .rotate    (rotate_c),
    .wr_en     (wr_vld_q),
    .wr_idx    (wr_idx_q),
    .wr_data   (bus.mem_rd_data),
    .rd_col    (col_ptr_q),
    .rd_window (win_c)
  );

  // State and output registers; read data trails the strobe by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rd_idx_q       <= '0;
      row_ptr_q      <= '0;
      col_ptr_q      <= '0;
      col_idx_q      <= '0;
      ack_q          <= ACK_IDLE;
      mem_rd_en_q    <= 1'b0;
      mem_rd_addr_q  <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      wr_vld_q       <= 1'b0;
      wr_idx_q       <= '0;
    end else begin
      state_q        <= state_n;
      rd_idx_q       <= rd_idx_n;
      row_ptr_q      <= row_ptr_n;
      col_ptr_q      <= col_ptr_n;
      col_idx_q      <= col_idx_n;
      ack_q          <= ack_n;
      mem_rd_en_q    <= mem_rd_en_n;
      mem_rd_addr_q  <= mem_rd_addr_n;
      window_q       <= window_n;
      window_valid_q <= window_valid_n;
      wr_vld_q       <= mem_rd_en_q;
      wr_idx_q       <= rd_idx_q;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n        = state_q;
    rd_idx_n       = rd_idx_q;
    row_ptr_n      = row_ptr_q;
    col_ptr_n      = col_ptr_q;
    col_idx_n      = col_idx_q;
    ack_n          = ACK_IDLE;
    mem_rd_en_n    = 1'b0;
    mem_rd_addr_n  = mem_rd_addr_q;
    window_n       = window_q;
    window_valid_n = 1'b0;
    rotate_c       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        case (cmd_e'(bus.cmd))
          CMD_LOAD: begin
            state_n       = ST_LOAD_RD;
            rotate_c      = 1'b1;
            rd_idx_n      = '0;
            mem_rd_en_n   = 1'b1;
            mem_rd_addr_n = ADDR_WIDTH'(32'(row_ptr_q) * IMAGE_SIZE);
          end
          CMD_SHIFT: begin
            state_n        = ST_SHIFT;
            ack_n          = ACK_SHIFT_FIN;
            window_valid_n = 1'b1;
            window_n       = win_c;
            col_idx_n      = col_ptr_q;
            col_ptr_n      = (col_ptr_q == ARRAY_WIDTH'(ARRAY_SIZE - 1)) ?
                             '0 : col_ptr_q + ARRAY_WIDTH'(1);
          end
          default: ;
        endcase
      end
      ST_LOAD_RD: begin
        if (rd_idx_q == IDX_WIDTH'(IMAGE_SIZE - 1)) begin
          state_n = ST_LOAD_WAIT;
        end else begin
          rd_idx_n      = rd_idx_q + IDX_WIDTH'(1);
          mem_rd_en_n   = 1'b1;
          mem_rd_addr_n = mem_rd_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_LOAD_WAIT: begin
        state_n   = ST_LOAD_ACK;
        ack_n     = ACK_LOAD_FIN;
        col_idx_n = '0;
        col_ptr_n = '0;
        row_ptr_n = (row_ptr_q == IDX_WIDTH'(IMAGE_SIZE - 1)) ?
                    '0 : row_ptr_q + IDX_WIDTH'(1);
      end
      ST_LOAD_ACK: state_n = ST_IDLE;
      ST_SHIFT:    state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  assign bus.ack          = ack_q;
  assign bus.mem_rd_en    = mem_rd_en_q;
  assign bus.mem_rd_addr  = mem_rd_addr_q;
  assign bus.window_data  = window_q;
  assign bus.window_valid = window_valid_q;
  assign bus.col_idx      = col_idx_q;

`ifdef CONV_INPUT_CMD_ERR_EN
  logic cmd_err_q;

  // Sticky: a command arriving while busy, or the reserved encoding at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_err_q <= 1'b0;
    end else if (((state_q != ST_IDLE) && (cmd_e'(bus.cmd) != CMD_IDLE)) ||
                 (cmd_e'(bus.cmd) == CMD_RSVD)) begin
      cmd_err_q <= 1'b1;
    end
  end

  assign cmd_err = cmd_err_q;
`endif

endmodule

// File: tb/tb_conv_input_interface.sv
// Self-checking bench for conv_input_interface: command table plus reset/abort sequences.
module tb_conv_input_interface;
  import conv_kernel_param::*;

  typedef struct {
    logic [1:0]  cmd;
    logic [5:0]  base;
    logic [63:0] w;
    logic [2:0]  col;
  } vec_t;

  typedef struct {
    logic [63:0] w;
    logic [2:0]  col;
  } win_exp_t;

  logic clk;
  logic rst;
`ifdef CONV_INPUT_CMD_ERR_EN
  logic cmd_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  logic [5:0]  addr_q [$];
  logic [1:0]  ack_q  [$];
  win_exp_t    win_q  [$];

  conv_input_interface_if #(.KERNEL_SIZE(2), .ARRAY_WIDTH(3), .DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

  conv_input_interface #(
    .KERNEL_SIZE(2), .ARRAY_SIZE(6), .ARRAY_WIDTH(3), .DATA_WIDTH(16), .ADDR_WIDTH(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CONV_INPUT_CMD_ERR_EN
    ,
    .cmd_err (cmd_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image memory: pixel value equals its address, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) bus.mem_rd_data <= 16'd0;
    else if (bus.mem_rd_en) bus.mem_rd_data <= 16'(bus.mem_rd_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input int base,
                              input int w0, input int w1, input int w2, input int w3,
                              input int col);
    vec_t v;
    v.cmd  = c;
    v.base = 6'(base);
    v.w    = {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
    v.col  = 3'(col);
    return v;
  endfunction

  task automatic push_load(input logic [5:0] base, input int n_reads, input logic with_ack);
    for (int k = 0; k < n_reads; k++) addr_q.push_back(6'(int'(base) + k));
    if (with_ack) ack_q.push_back(ACK_LOAD_FIN);
  endtask

  // Scoreboard: every read strobe, ack and window must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_rd_en) begin
        if (addr_q.size() == 0) begin
          chk("unexpected mem_rd_en (addr)", 64'(bus.mem_rd_addr), 64'h3f_dead);
        end else begin
          chk("mem_rd_addr", 64'(bus.mem_rd_addr), 64'(addr_q.pop_front()));
        end
      end
      if (bus.ack != 2'(ACK_IDLE)) begin
        if (ack_q.size() == 0) begin
          chk("unexpected ack", 64'(bus.ack), 64'(ACK_IDLE));
        end else begin
          chk("ack value", 64'(bus.ack), 64'(ack_q.pop_front()));
        end
      end
      if (bus.window_valid) begin
        if (win_q.size() == 0) begin
          chk("unexpected window_valid", 64'(bus.window_valid), 64'd0);
        end else begin
          win_exp_t e;
          e = win_q.pop_front();
          chk("window_data", bus.window_data, e.w);
          chk("col_idx", 64'(bus.col_idx), 64'(e.col));
          chk("ack with window", 64'(bus.ack), 64'(ACK_SHIFT_FIN));
        end
      end
    end
  end

  // Issue one command and return the cycles until ack (0 if it never came).
  task automatic run_cmd(input vec_t v, output int lat);
    bus.cmd = v.cmd;
    if (v.cmd == 2'(CMD_LOAD)) begin
      push_load(v.base, 7, 1'b1);
    end else begin
      win_exp_t e;
      e.w = v.w;
      e.col = v.col;
      win_q.push_back(e);
      ack_q.push_back(ACK_SHIFT_FIN);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      bus.cmd = 2'(CMD_IDLE);
      if (bus.ack != 2'(ACK_IDLE)) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [18];
    vec_t v;
    logic [63:0] last_win;
    int lat;

    vecs[0]  = mk(CMD_LOAD,   0,  0, 0,  0,  0, 0);
    vecs[1]  = mk(CMD_LOAD,   7,  0, 0,  0,  0, 0);
    vecs[2]  = mk(CMD_SHIFT,  0,  0, 1,  7,  8, 0);
    vecs[3]  = mk(CMD_SHIFT,  0,  1, 2,  8,  9, 1);
    vecs[4]  = mk(CMD_SHIFT,  0,  2, 3,  9, 10, 2);
    vecs[5]  = mk(CMD_SHIFT,  0,  3, 4, 10, 11, 3);
    vecs[6]  = mk(CMD_SHIFT,  0,  4, 5, 11, 12, 4);
    vecs[7]  = mk(CMD_SHIFT,  0,  5, 6, 12, 13, 5);
    vecs[8]  = mk(CMD_SHIFT,  0,  0, 1,  7,  8, 0);
    vecs[9]  = mk(CMD_LOAD,  14,  0, 0,  0,  0, 0);
    vecs[10] = mk(CMD_SHIFT,  0,  7, 8, 14, 15, 0);
    vecs[11] = mk(CMD_SHIFT,  0,  8, 9, 15, 16, 1);
    vecs[12] = mk(CMD_LOAD,  21,  0, 0,  0,  0, 0);
    vecs[13] = mk(CMD_LOAD,  28,  0, 0,  0,  0, 0);
    vecs[14] = mk(CMD_LOAD,  35,  0, 0,  0,  0, 0);
    vecs[15] = mk(CMD_LOAD,  42,  0, 0,  0,  0, 0);
    vecs[16] = mk(CMD_LOAD,   0,  0, 0,  0,  0, 0);
    vecs[17] = mk(CMD_SHIFT,  0, 42, 43, 0,  1, 0);

    rst = 1'b1;
    bus.cmd = 2'(CMD_IDLE);
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 64'(bus.ack), 64'(ACK_IDLE));
    chk("reset mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("reset mem_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
    chk("reset window_data", bus.window_data, 64'd0);
    chk("reset window_valid", 64'(bus.window_valid), 64'd0);
    chk("reset col_idx", 64'(bus.col_idx), 64'd0);
`ifdef CONV_INPUT_CMD_ERR_EN
    chk("reset cmd_err", 64'(cmd_err), 64'd0);
`endif
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    last_win = 64'd0;
    for (int i = 0; i < 18; i++) begin
      run_cmd(vecs[i], lat);
      chk($sformatf("vec%0d latency", i), 64'(lat),
          (vecs[i].cmd == 2'(CMD_LOAD)) ? 64'd9 : 64'd1);
      if (vecs[i].cmd == 2'(CMD_LOAD)) begin
        chk($sformatf("vec%0d window held over load", i), bus.window_data, last_win);
        chk($sformatf("vec%0d col_idx cleared by load", i), 64'(bus.col_idx), 64'd0);
      end else begin
        last_win = vecs[i].w;
      end
      @(posedge clk); #1;
    end

    // Shift issued in the middle of a load is ignored.
    bus.cmd = 2'(CMD_LOAD);
    push_load(6'd7, 7, 1'b1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      bus.cmd = (i == 3) ? 2'(CMD_SHIFT) : 2'(CMD_IDLE);
      if (bus.ack != 2'(ACK_IDLE)) begin
        lat = i;
        break;
      end
    end
    chk("load with stray shift latency", 64'(lat), 64'd9);
    chk("window held after stray shift", bus.window_data, last_win);
`ifdef CONV_INPUT_CMD_ERR_EN
    chk("cmd_err set by busy shift", 64'(cmd_err), 64'd1);
`endif
    @(posedge clk); #1;
`ifdef CONV_INPUT_CMD_ERR_EN
    chk("cmd_err sticky", 64'(cmd_err), 64'd1);
`endif

    // Reset during a load: four reads go out, no ack, everything clears.
    bus.cmd = 2'(CMD_LOAD);
    push_load(6'd14, 4, 1'b0);
    @(posedge clk); #1;
    bus.cmd = 2'(CMD_IDLE);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort ack", 64'(bus.ack), 64'(ACK_IDLE));
    chk("abort mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("abort mem_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
    chk("abort window_data", bus.window_data, 64'd0);
    chk("abort window_valid", 64'(bus.window_valid), 64'd0);
    chk("abort col_idx", 64'(bus.col_idx), 64'd0);
    chk("abort reads consumed", 64'(addr_q.size()), 64'd0);
`ifdef CONV_INPUT_CMD_ERR_EN
    chk("cmd_err cleared by rst", 64'(cmd_err), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    v = mk(CMD_LOAD, 0, 0, 0, 0, 0, 0);
    run_cmd(v, lat);
    chk("load after abort latency", 64'(lat), 64'd9);
    chk("window zero after abort", bus.window_data, 64'd0);
    @(posedge clk); #1;
    v = mk(CMD_SHIFT, 0, 0, 0, 0, 1, 0);
    run_cmd(v, lat);
    chk("shift after abort latency", 64'(lat), 64'd1);
    @(posedge clk); #1;

    // Reserved command in IDLE does nothing visible.
    bus.cmd = 2'(CMD_RSVD);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.cmd = 2'(CMD_IDLE);
      chk($sformatf("reserved cmd ack cycle %0d", i), 64'(bus.ack), 64'(ACK_IDLE));
      chk($sformatf("reserved cmd rd_en cycle %0d", i), 64'(bus.mem_rd_en), 64'd0);
    end
`ifdef CONV_INPUT_CMD_ERR_EN
    chk("cmd_err set by reserved cmd", 64'(cmd_err), 64'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("addr queue drained", 64'(addr_q.size()), 64'd0);
    chk("ack queue drained", 64'(ack_q.size()), 64'd0);
    chk("window queue drained", 64'(win_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_input_interface.md
Name: conv_input_interface

Overview:
- Input-side stage of the conv layer; executes the load/shift commands that the conv layer controller issues on its 2-bit cmd/ack handshake.
- Fetches image rows from an external single-port image memory into a KERNEL_SIZE-row line buffer.
- Presents one KERNEL_SIZE x KERNEL_SIZE pixel window per shift to the conv kernel array.

Parameters:
- KERNEL_SIZE, 2, window edge length and number of buffered rows
- ARRAY_SIZE, 6, output positions per row (shifts per loaded row)
- ARRAY_WIDTH, 3, width of column index
- DATA_WIDTH, 16, pixel width
- ADDR_WIDTH, 6, image memory address width
- IMAGE_SIZE (localparam), ARRAY_SIZE+KERNEL_SIZE-1 = 7, pixels per image row and rows per image

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd  in  2  command from controller: CMD_IDLE=0, CMD_LOAD=1, CMD_SHIFT=2; 3 reserved
- ack  out  2  ACK_IDLE=0, ACK_LOAD_FIN=1, ACK_SHIFT_FIN=2; one-cycle pulse
- mem_rd_en  out  1  image memory read strobe
- mem_rd_addr  out  ADDR_WIDTH  image memory address
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- window_data  out  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  window element (r,c) at bits [(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest row
- window_valid  out  1  one-cycle pulse, coincident with ACK_SHIFT_FIN
- col_idx  out  ARRAY_WIDTH  column of the window currently on window_data

Behaviour:
- The clock is clk; reset rst is synchronous and active-high. There is one clock domain.
- Reset values:
  - ack=ACK_IDLE, mem_rd_en=0, mem_rd_addr=0, window_data=0, window_valid=0, col_idx=0.
  - Line buffer is cleared to 0.
  - Row and address pointers are cleared to 0.
  - State is IDLE.
- A reset asserted mid-load aborts the load: no ack is produced, and the next load starts at address 0.
- States:
  - IDLE: cmd is sampled only here.
    - CMD_LOAD -> LOAD_RD.
    - CMD_SHIFT -> SHIFT.
    - CMD_IDLE or 3 -> stay in IDLE.
  - LOAD_RD: mem_rd_en=1 for IMAGE_SIZE consecutive cycles.
    - Address increments by 1 each cycle.
    - After the IMAGE_SIZE-th read -> LOAD_WAIT.
  - LOAD_WAIT: captures the final datum, then -> LOAD_ACK.
  - LOAD_ACK: ack=ACK_LOAD_FIN for 1 cycle; col_idx is cleared to 0; -> IDLE.
  - SHIFT: window_data is registered from columns col_idx..col_idx+KERNEL_SIZE-1 of all buffered rows.
    - ack=ACK_SHIFT_FIN and window_valid=1 for 1 cycle.
    - -> IDLE.
- Load data path:
  - Each returned pixel is written into the newest row slot at its pixel index.
  - At load start, rows shift one slot toward older: the oldest row is discarded and the newest slot is overwritten.
- Latency:
  - LOAD: ack asserted IMAGE_SIZE+2 cycles after the cycle in which cmd was sampled (9 at defaults).
  - SHIFT: ack and window asserted 1 cycle after cmd was sampled.
- Wrap rules:
  - mem_rd_addr wraps to 0 after IMAGE_SIZE*IMAGE_SIZE-1, i.e. after the last image row.
  - Image row pointer wraps IMAGE_SIZE-1 -> 0.
  - col_idx advances after each shift and wraps ARRAY_SIZE-1 -> 0.
- Commands received in any non-IDLE state are ignored. cmd is a one-cycle pulse by protocol.
- window_data holds its value between shifts.
- ack is ACK_IDLE in every cycle not listed above.

Optional Feature:
- Macro: CONV_INPUT_CMD_ERR_EN.
- With the macro defined:
  - Adds output cmd_err (1 bit), a sticky flag.
  - cmd_err is set when a non-IDLE cmd arrives outside IDLE, or cmd==3 arrives in any state.
  - Cleared only by rst.
- Without it: the port and its logic are absent; such commands are silently ignored.

Decomposition:
- Shared package conv_kernel_param holds the CMD_* and ACK_* encodings.
- One sub-module is natural: conv_line_buffer.
  - Contents: KERNEL_SIZE x IMAGE_SIZE register array.
  - Interfaces: row-rotate strobe, write port (index, data), combinational window read port at a column.
- Top level holds the FSM, address/row/col counters, and output registers.

Test Plan:
- Memory model with data = address. rst, then CMD_LOAD at cycle t -> mem_rd_en high t+1..t+7 with addr 0..6; ack=1 at t+9 only; no other ack.
- Two loads, then CMD_SHIFT -> next cycle ack=2, window_valid=1, window={0,1,7,8} (r0c0,r0c1,r1c0,r1c1), col_idx=0.
- Six consecutive shifts after two loads -> windows end with {5,6,12,13}; col_idx values 0..5, then wraps to 0; a third load resets col_idx to 0 and the window becomes rows 1,2: first shift {7,8,14,15}.
- Eight loads -> the 8th load reads addresses 0..6 again; row pointer wraps.
- CMD_SHIFT injected during a load -> ignored; load ack still at t+9; no window_valid. With CONV_INPUT_CMD_ERR_EN defined, cmd_err=1 and held until rst.
- rst asserted at t+4 of a load -> no ack; all outputs 0 next cycle; the next load reads from address 0.
